sha_uart_msg_ctrl: RTL

- Controls a UART-attached SHA-256 hasher for variable-length messages.
- Buffers received UART bytes until a terminator character or MAX_LEN bytes arrive.
- Streams the buffered bytes into the sha256 core, then emits the digest as 2*DIGEST_BITS/8 hex ASCII characters through the uart_tx send/busy handshake.
- Sits between uart_rx/uart_tx and sha256 in the top level. It replaces the fixed 3-byte framing with a parametrised message length and terminator.

---
 rtl/sha_uart_pkg.sv | 18 +
 rtl/msg_byte_buffer.sv | 18 +
 rtl/sha_uart_msg_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sha_uart_pkg.sv
// sha_uart_pkg: shared state encoding, ASCII constants and hex helper for sha_uart_msg_ctrl.
// SHA_UART_CRLF_EN adds the SEND_EOL state for the CR/LF trailer.
package sha_uart_pkg;
`ifdef SHA_UART_CRLF_EN
  typedef enum logic [2:0] {RECV, FEED, WAIT_HASH, SEND, SEND_EOL} state_t;
`else
  typedef enum logic [2:0] {RECV, FEED, WAIT_HASH, SEND} state_t;
`endif
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
    return (nibble < 4'd10) ? ASCII_0 + {4'd0, nibble}
                            : (upper ? ASCII_UA : ASCII_LA) + {4'd0, nibble} - 8'd10;
  endfunction
endpackage

// File: rtl/msg_byte_buffer.sv
// msg_byte_buffer: DEPTH x 8 RAM, one write port and a registered read port; storage is not reset.
module msg_byte_buffer #(
  parameter int DEPTH = 64,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sha_uart_msg_ctrl.sv
// sha_uart_msg_ctrl: buffers a terminated UART message, streams it into sha256, returns the digest as hex ASCII.
// Define SHA_UART_CRLF_EN to append CR LF after the hex digest.
module sha_uart_msg_ctrl
  import sha_uart_pkg::*;
#(
  parameter int         MAX_LEN     = 64,
  parameter logic [7:0] TERM_CHAR   = 8'h0A,
  parameter int         DIGEST_BITS = 256,
  parameter bit         HEX_UPPER   = 1'b0
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         sha_reset,
  output logic                         sha_valid,
  output logic [7:0]                   sha_data,
  output logic                         sha_data_end,
  input  logic                         sha_delay,
  input  logic                         sha_done,
  input  logic [DIGEST_BITS-1:0]       sha_hash,
  output logic [7:0]                   tx_data,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [$clog2(MAX_LEN+1)-1:0] msg_len,
  output logic                         overflow,
  output logic                         dropped
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int NW = $clog2(DIGEST_BITS / 4);
  localparam logic [NW-1:0] LAST_NIB = NW'(DIGEST_BITS / 4 - 1);

  state_t                 state;
  logic [LW-1:0]          wr_ptr, rd_ptr;
  logic [NW-1:0]          nib;
  logic [DIGEST_BITS-1:0] hash_reg;
  logic                   primed, wait_low, we, accept, last_char;
  logic [AW-1:0]          raddr;
  logic [7:0]             rdata, cur_char;
`ifdef SHA_UART_CRLF_EN
  logic                   eol;
`endif

  assign we           = state == RECV && rx_valid && rx_data != TERM_CHAR;
  assign accept       = state == FEED && primed && !sha_delay;
  // Look one address ahead on accept so the registered read keeps up without bubbles.
  assign raddr        = accept ? rd_ptr[AW-1:0] + 1'b1 : rd_ptr[AW-1:0];
  assign sha_valid    = accept;
  assign sha_data     = accept ? rdata : 8'h00;
  assign sha_data_end = accept && rd_ptr == msg_len - 1'b1;

  always_comb begin
`ifdef SHA_UART_CRLF_EN
    cur_char  = state == SEND_EOL ? (eol ? ASCII_LF : ASCII_CR)
                                  : nibble_to_ascii(hash_reg[DIGEST_BITS-1 -: 4], HEX_UPPER);
    last_char = state == SEND_EOL && eol;
`else
    cur_char  = nibble_to_ascii(hash_reg[DIGEST_BITS-1 -: 4], HEX_UPPER);
    last_char = nib == LAST_NIB;
`endif
  end

  msg_byte_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .CLK   (CLK),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= RECV;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      nib       <= '0;
      msg_len   <= '0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
      sha_reset <= 1'b1;
      tx_send   <= 1'b0;
      tx_data   <= '0;
      hash_reg  <= '0;
      primed    <= 1'b0;
      wait_low  <= 1'b0;
`ifdef SHA_UART_CRLF_EN
      eol       <= 1'b0;
`endif
    end else begin
      if (rx_valid && state != RECV) dropped <= 1'b1;
      case (state)
        RECV: if (rx_valid) begin
          if (rx_data != TERM_CHAR) begin
            wr_ptr  <= wr_ptr + 1'b1;
            msg_len <= wr_ptr + 1'b1;
            if (wr_ptr == '0) begin
              overflow <= 1'b0;
              dropped  <= 1'b0;
            end
            if (wr_ptr == LW'(MAX_LEN - 1)) begin
              overflow  <= 1'b1;
              state     <= FEED;
              sha_reset <= 1'b0;
            end
          end else if (wr_ptr != '0) begin
            state     <= FEED;
            sha_reset <= 1'b0;
          end
        end
        FEED: begin
          primed <= 1'b1;
          if (accept) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (sha_data_end) begin
              state  <= WAIT_HASH;
              primed <= 1'b0;
            end
          end
        end
        WAIT_HASH: if (sha_done) begin
          hash_reg <= sha_hash;
          nib      <= '0;
          state    <= SEND;
        end
        default: begin
          // Load, hold until busy is seen, then wait for busy to fall before the next character.
          if (!tx_send && !tx_busy && !wait_low) begin
            tx_data <= cur_char;
            tx_send <= 1'b1;
          end else if (tx_send && tx_busy) begin
            tx_send  <= 1'b0;
            wait_low <= 1'b1;
          end else if (wait_low && !tx_busy) begin
            wait_low <= 1'b0;
            if (last_char) begin
              state     <= RECV;
              sha_reset <= 1'b1;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
`ifdef SHA_UART_CRLF_EN
              eol       <= 1'b0;
            end else if (state == SEND_EOL) begin
              eol       <= 1'b1;
            end else if (nib == LAST_NIB) begin
              state     <= SEND_EOL;
`endif
            end else begin
              nib      <= nib + 1'b1;
              hash_reg <= hash_reg << 4;
            end
          end
        end
      endcase
    end
  end
endmodule
